// File: rtl/digest_word_serializer_pkg.sv
// Shared encodings for the digest word serializer and the host readback controller.
package digest_word_serializer_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_t;

   localparam logic MODE_SINGLE = 1'b0;
   localparam logic MODE_SEQ    = 1'b1;

endpackage

// File: rtl/digest_word_serializer_mux_n1.sv
// Combinational WIDTH-bit NUM_IN:1 word mux; out-of-range selects return zero.
module mux_n1 #(
   parameter int WIDTH  = 32,
   parameter int NUM_IN = 8,
   parameter int SEL_W  = $clog2(NUM_IN)
) (
   input  logic [NUM_IN*WIDTH-1:0] i_data,
   input  logic [SEL_W-1:0]        i_sel,
   output logic [WIDTH-1:0]        o_data
);

   always_comb begin
      o_data = '0;
      for (int k = 0; k < NUM_IN; k++) begin
         if (i_sel == SEL_W'(k)) begin
            o_data = i_data[k*WIDTH +: WIDTH];
         end
      end
   end

endmodule

// File: rtl/digest_word_serializer.sv
// Captures NUM_IN words in one cycle and emits one selected word or all words in
// index order over a valid/ready port.
//
// state   | meaning
// ST_IDLE | no capture held; waiting for start_i
// ST_SEND | bank captured; presenting bank[idx] until the last beat is accepted
module digest_word_serializer
   import digest_word_serializer_pkg::*;
#(
   parameter  int WIDTH  = 32,
   parameter  int NUM_IN = 8,
   localparam int SEL_W  = $clog2(NUM_IN)
) (
   input  logic                    clk_i,
   input  logic                    rst_n_i,
   input  logic                    start_i,
   input  logic                    mode_i,
   input  logic [SEL_W-1:0]        sel_i,
   input  logic [NUM_IN*WIDTH-1:0] din_i,
   input  logic                    ready_i,
   output logic                    busy_o,
   output logic                    valid_o,
   output logic [WIDTH-1:0]        dout_o,
   output logic [SEL_W-1:0]        idx_o,
   output logic                    last_o
);

   localparam logic [SEL_W-1:0] LP_IDX_PENULT = SEL_W'(NUM_IN - 2);

   state_t                    r_state;
   state_t                    w_state_nxt;
   logic [NUM_IN*WIDTH-1:0]   r_bank;
   logic                      r_mode;
   logic [SEL_W-1:0]          r_idx;
   logic                      r_last;
   logic                      w_capture;
   logic                      w_beat;
   logic [WIDTH-1:0]          w_mux_out;

   assign w_capture = (r_state == ST_IDLE) && start_i;
   assign w_beat    = (r_state == ST_SEND) && ready_i;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (start_i)          w_state_nxt = ST_SEND;
         ST_SEND: if (ready_i && r_last) w_state_nxt = ST_IDLE;
         default:                       w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      busy_o  = 1'b0;
      valid_o = 1'b0;
      if (r_state == ST_SEND) begin
         busy_o  = 1'b1;
         valid_o = 1'b1;
      end
   end

   // Bank, index and idx hold after the final beat so dout_o/idx_o keep their last values.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_bank <= '0;
         r_mode <= MODE_SINGLE;
         r_idx  <= '0;
         r_last <= 1'b0;
      end else if (w_capture) begin
         r_bank <= din_i;
         r_mode <= mode_i;
         if (mode_i == MODE_SEQ) begin
            r_idx  <= '0;
            r_last <= (NUM_IN == 1);
         end else begin
            r_idx  <= sel_i;
            r_last <= 1'b1;
         end
      end else if (w_beat) begin
         if (r_last) begin
            r_last <= 1'b0;
         end else begin
            r_idx  <= r_idx + SEL_W'(1);
            r_last <= (r_mode == MODE_SINGLE) || (r_idx == LP_IDX_PENULT);
         end
      end
   end

   mux_n1 #(
      .WIDTH  (WIDTH),
      .NUM_IN (NUM_IN),
      .SEL_W  (SEL_W)
   ) u_mux (
      .i_data (r_bank),
      .i_sel  (r_idx),
      .o_data (w_mux_out)
   );

   assign dout_o = w_mux_out;
   assign idx_o  = r_idx;
   assign last_o = r_last;

endmodule

// File: doc/digest_word_serializer.md
# digest_word_serializer

Parametrised successor to the team's combinational 32-bit 8:1 word mux. It captures NUM_IN words of WIDTH bits in one cycle, then emits them through a registered valid/ready output port. In single mode it emits one selected word; in sequence mode it emits all words in index order. It sits between the SHA-256 working-variable/digest registers and the host readback path, replacing direct mux selection.

## Interface
- WIDTH, 32, bits per word
- NUM_IN, 8, number of input words (2..16)
- SEL_W, $clog2(NUM_IN), index width (derived; do not override)

- clk_i  input  1  clock, rising edge
- rst_n_i  input  1  asynchronous active-low reset
- start_i  input  1  capture request; honoured only when busy_o=0
- mode_i  input  1  0 = single word, 1 = sequence all words; sampled with start_i
- sel_i  input  SEL_W  word index for single mode; sampled with start_i
- din_i  input  NUM_IN*WIDTH  packed words, word k at [k*WIDTH +: WIDTH]
- ready_i  input  1  downstream accepts dout_o
- busy_o  output  1  capture held, transfer in progress
- valid_o  output  1  dout_o holds a word
- dout_o  output  WIDTH  current word (registered)
- idx_o  output  SEL_W  index of the word on dout_o
- last_o  output  1  current word is the final beat of this transfer

## Operation
- States: IDLE, SEND.
- IDLE: busy_o=0, valid_o=0, last_o=0. When start_i=1:
  - Copy din_i into an internal bank of NUM_IN registers.
  - Latch mode_i.
  - Move to SEND.
- SEND entry, single mode: idx=sel_i, last_o=1.
- SEND entry, sequence mode: idx=0, last_o=(NUM_IN==1 ? 1 : 0), so 0 for every legal NUM_IN.
- In SEND: valid_o=1 and dout_o=bank[idx]. A handshake occurs when valid_o & ready_i:
  - If last_o=1: go to IDLE. valid_o, busy_o and last_o drop on the next edge. dout_o and idx_o hold their last values.
  - Otherwise: idx increments, dout_o becomes bank[idx+1], and last_o is set when idx+1 = NUM_IN-1.
- Out-of-range sel_i (≥ NUM_IN, possible only when NUM_IN is not a power of two): a single beat with dout_o=0, idx_o=sel_i, last_o=1.
- start_i while busy_o=1 is ignored. It is not queued.
- Changes to din_i after capture never affect output.

## Timing
- Reset (async assert, sync release): state=IDLE, busy_o=0, valid_o=0, last_o=0, dout_o=0, idx_o=0, bank=0.
- Latency: start_i sampled high at edge t gives valid_o=1 with the first word after edge t. busy_o also rises after edge t.
- Throughput: one word per cycle with ready_i held high. A sequence takes NUM_IN cycles in SEND, so the next start is accepted at the earliest one cycle after the final beat.
- Stall: while valid_o=1 and ready_i=0, dout_o, idx_o and last_o hold stable.
- Final beat with start_i=1 in the same cycle: start is ignored, because busy_o is still 1 in that cycle.
- ready_i while valid_o=0 has no effect.
- Reset mid-transfer: all outputs return to reset values immediately. No beat is completed.

## Structure
- Shared package: the state encoding (IDLE=1'b0, SEND=1'b1) and the mode constants (MODE_SINGLE=1'b0, MODE_SEQ=1'b1), reused by the host readback controller.
- One sub-module: mux_n1, a parametrised combinational WIDTH-bit NUM_IN:1 mux that returns 0 for out-of-range selects. It is instantiated once on the bank, with idx as the select. The FSM, bank, counter and output registers live in the top module.

## Test plan
Use NUM_IN=8, WIDTH=32, and din_i = SHA-256 H0..H7 (word0=0x6a09e667 … word7=0x5be0cd19) unless stated otherwise.

- Single mode, sel_i=3, ready_i=1: one beat, dout_o=0xa54ff53a, idx_o=3, last_o=1. valid_o is high for exactly 1 cycle, then busy_o=0.
- Sequence mode, ready_i=1: 8 consecutive beats 0x6a09e667…0x5be0cd19, idx_o 0..7, last_o only on idx 7. busy_o is high for 8 cycles.
- Sequence mode with ready_i low on beats 2 and 5 for 3 cycles each: dout_o and idx_o hold during the stalls. Total 14 cycles. No word is lost or duplicated.
- Overwrite din_i with 0xFFFFFFFF words one cycle after start_i, and pulse start_i with mode_i=0 mid-sequence: output is still the original H0..H7 sequence and the second start is ignored.
- Assert rst_n_i=0 at beat 4 of a sequence: valid_o, busy_o, last_o, dout_o and idx_o go to 0 without waiting for the clock. After release, start_i begins a fresh sequence at idx 0.
- NUM_IN=5, single mode with sel_i=6: one beat with dout_o=0, idx_o=6, last_o=1, then IDLE.
